mem_access_splitter: RTL and testbench

Request adapter that sits directly upstream of the data memory hierarchy and drives its start_access/access_done port. It accepts processor loads and stores of 1, 2, 4 or 8 bytes at any byte address. Each request becomes one or two aligned 64-bit memory accesses with the correct bytemask. Load data is realigned and zero- or sign-extended, and one response per request is returned over a valid/ready handshake.

---
 rtl/mem_req_pkg.sv | 30 +++
 rtl/mem_lane_align.sv | 34 +++
 rtl/mem_access_splitter.sv | 142 ++++++++++++++
 tb/tb_mem_access_splitter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// rtl/mem_req_pkg.sv - shared types and lane-mask helper for the memory access splitter
package mem_req_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RSP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_1B = 2'd0,
    SZ_2B = 2'd1,
    SZ_4B = 2'd2,
    SZ_8B = 2'd3
  } size_t;

  // Byte-lane mask over two consecutive 64-bit words; bits [15:8] select the second word.
  function automatic logic [15:0] mask_for(input logic [1:0] size, input logic [2:0] offset);
    logic [15:0] base;
    case (size)
      SZ_1B:   base = 16'h0001;
      SZ_2B:   base = 16'h0003;
      SZ_4B:   base = 16'h000F;
      default: base = 16'h00FF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane placement and load realign/extend (combinational)
module mem_lane_align
  import mem_req_pkg::*;
(
  input  logic [1:0]   size,
  input  logic [2:0]   offset,
  input  logic         sign_ext,
  input  logic [63:0]  wdata,
  input  logic [63:0]  lo_word,
  input  logic [63:0]  hi_word,
  output logic [15:0]  mask16,
  output logic [127:0] wdata128,
  output logic [63:0]  rdata
);

  logic [5:0]  sh;
  logic [63:0] shifted;

  assign sh       = {offset, 3'b000};
  assign mask16   = mask_for(size, offset);
  assign wdata128 = {64'd0, wdata} << sh;
  assign shifted  = 64'({hi_word, lo_word} >> sh);

  always_comb begin
    rdata = 64'd0;
    case (size)
      SZ_1B:   rdata = sign_ext ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
      SZ_2B:   rdata = sign_ext ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
      SZ_4B:   rdata = sign_ext ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_splitter.sv
// rtl/mem_access_splitter.sv - splits unaligned 1/2/4/8-byte requests into aligned 64-bit memory accesses
module mem_access_splitter
  import mem_req_pkg::*;
#(
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [63:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [63:0]   rsp_rdata,
  output logic [AW-1:0] mem_address,
  output logic [63:0]   mem_data_in,
  output logic [7:0]    mem_bytemask,
  output logic          mem_write,
  output logic          mem_start_access,
  input  logic          mem_access_done,
  input  logic [63:0]   mem_data_out
);

  state_t      state;
  logic [2:0]  r_offset;
  logic [1:0]  r_size;
  logic        r_write;
  logic        r_signed;
  logic [63:0] r_wdata;
  logic [63:0] lo_buf;
  logic [63:0] hi_buf;

  logic [1:0]   a_size;
  logic [2:0]   a_offset;
  logic [63:0]  a_wdata;
  logic [63:0]  lo_word;
  logic [63:0]  hi_word;
  logic [15:0]  mask16;
  logic [127:0] wdata128;
  logic [63:0]  rdata;
  logic         split;

  assign req_ready = (state == IDLE);

  // In IDLE the aligner sees the incoming request so LO outputs can be registered on accept.
  assign a_size   = req_ready ? req_size       : r_size;
  assign a_offset = req_ready ? req_addr[2:0]  : r_offset;
  assign a_wdata  = req_ready ? req_wdata      : r_wdata;

  // The response is built on the final done edge, before the buffer itself is updated.
  assign lo_word = (state == LO) ? mem_data_out : lo_buf;
  assign hi_word = (state == HI) ? mem_data_out : hi_buf;
  assign split   = |mask16[15:8];

  mem_lane_align u_align (
    .size     (a_size),
    .offset   (a_offset),
    .sign_ext (r_signed),
    .wdata    (a_wdata),
    .lo_word  (lo_word),
    .hi_word  (hi_word),
    .mask16   (mask16),
    .wdata128 (wdata128),
    .rdata    (rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      r_offset         <= 3'd0;
      r_size           <= 2'd0;
      r_write          <= 1'b0;
      r_signed         <= 1'b0;
      r_wdata          <= 64'd0;
      lo_buf           <= 64'd0;
      hi_buf           <= 64'd0;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= 64'd0;
      mem_address      <= '0;
      mem_data_in      <= 64'd0;
      mem_bytemask     <= 8'd0;
      mem_write        <= 1'b0;
      mem_start_access <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_offset         <= req_addr[2:0];
            r_size           <= req_size;
            r_write          <= req_write;
            r_signed         <= req_signed;
            r_wdata          <= req_wdata;
            mem_address      <= {req_addr[AW-1:3], 3'b000};
            mem_bytemask     <= mask16[7:0];
            mem_data_in      <= wdata128[63:0];
            mem_write        <= req_write;
            mem_start_access <= 1'b1;
            state            <= LO;
          end
        end
        LO: begin
          if (mem_access_done) begin
            lo_buf <= mem_data_out;
            if (split) begin
              // Start strobe stays high; the second word follows with no idle cycle.
              mem_address  <= mem_address + AW'(8);
              mem_bytemask <= mask16[15:8];
              mem_data_in  <= wdata128[127:64];
              state        <= HI;
            end else begin
              mem_start_access <= 1'b0;
              rsp_valid        <= 1'b1;
              rsp_rdata        <= r_write ? 64'd0 : rdata;
              state            <= RSP;
            end
          end
        end
        HI: begin
          if (mem_access_done) begin
            hi_buf           <= mem_data_out;
            mem_start_access <= 1'b0;
            rsp_valid        <= 1'b1;
            rsp_rdata        <= r_write ? 64'd0 : rdata;
            state            <= RSP;
          end
        end
        default: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 64'd0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_splitter.sv
// tb/tb_mem_access_splitter.sv - directed self-checking bench with a fixed-latency memory model
module tb_mem_access_splitter;

  localparam int AW  = 20;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [63:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [63:0]   rsp_rdata;
  logic [AW-1:0] mem_address;
  logic [63:0]   mem_data_in;
  logic [7:0]    mem_bytemask;
  logic          mem_write;
  logic          mem_start_access;
  logic          mem_access_done;
  logic [63:0]   mem_data_out;

  always #5 clk = ~clk;

  mem_access_splitter #(.AW(AW)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_bytemask     (mem_bytemask),
    .mem_write        (mem_write),
    .mem_start_access (mem_start_access),
    .mem_access_done  (mem_access_done),
    .mem_data_out     (mem_data_out)
  );

  // Memory: completes each access LAT cycles after it is seen, logging address and mask.
  logic [63:0]   mem [0:(1<<(AW-3))-1];
  int            cnt;
  logic [AW-1:0] log_addr [$];
  logic [7:0]    log_mask [$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_access_done <= 1'b0;
      mem_data_out    <= 64'd0;
      cnt             <= 0;
    end else begin
      mem_access_done <= 1'b0;
      if (mem_start_access && !mem_access_done) begin
        if (cnt == LAT - 1) begin
          cnt             <= 0;
          mem_access_done <= 1'b1;
          mem_data_out    <= mem[mem_address[AW-1:3]];
          log_addr.push_back(mem_address);
          log_mask.push_back(mem_bytemask);
          if (mem_write)
            for (int b = 0; b < 8; b++)
              if (mem_bytemask[b]) mem[mem_address[AW-1:3]][8*b +: 8] <= mem_data_in[8*b +: 8];
        end else begin
          cnt <= cnt + 1;
        end
      end
    end
  end

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [AW-1:0] a, input logic [63:0] wd, input bit consume,
                        output logic [63:0] rd, output bit got, output bit start_ok);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    start_ok  = mem_start_access && !req_ready;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    rd = rsp_rdata;
    if (consume && got) begin
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end
  endtask

  task automatic run(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [AW-1:0] a, input logic [63:0] wd,
                     input logic [63:0] exp_rd, input int exp_n);
    logic [63:0] rd;
    bit got, sok;
    int base;
    base = log_addr.size();
    do_req(wr, sz, sg, a, wd, 1'b1, rd, got, sok);
    chk({tag, "_rsp"}, 64'(got), 64'd1);
    chk({tag, "_start"}, 64'(sok), 64'd1);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_naccess"}, 64'(log_addr.size() - base), 64'(exp_n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    bit got, sok;
    int base, bad;

    reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
    req_size = 2'd0; req_signed = 1'b0; req_wdata = 64'd0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_start", 64'(mem_start_access), 64'd0);
    chk("rst_write", 64'(mem_write), 64'd0);
    chk("rst_addr", 64'(mem_address), 64'd0);
    chk("rst_data_in", mem_data_in, 64'd0);
    chk("rst_mask", 64'(mem_bytemask), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    base = log_addr.size();
    run("st8", 1'b1, 2'd3, 1'b0, 20'h08000, 64'h1122334455667788, 64'd0, 1);
    chk("st8_addr", 64'(log_addr[base]), 64'h08000);
    chk("st8_mask", 64'(log_mask[base]), 64'hFF);
    run("ld8", 1'b0, 2'd3, 1'b0, 20'h08000, 64'd0, 64'h1122334455667788, 1);

    base = log_addr.size();
    run("st1", 1'b1, 2'd0, 1'b0, 20'h08007, 64'h80, 64'd0, 1);
    chk("st1_mask", 64'(log_mask[base]), 64'h80);
    run("ld1s", 1'b0, 2'd0, 1'b1, 20'h08007, 64'd0, 64'hFFFFFFFFFFFFFF80, 1);
    run("ld1u", 1'b0, 2'd0, 1'b0, 20'h08007, 64'd0, 64'h80, 1);

    base = log_addr.size();
    run("st2", 1'b1, 2'd1, 1'b0, 20'h08007, 64'hBEEF, 64'd0, 2);
    chk("st2_addr0", 64'(log_addr[base]), 64'h08000);
    chk("st2_mask0", 64'(log_mask[base]), 64'h80);
    chk("st2_addr1", 64'(log_addr[base+1]), 64'h08008);
    chk("st2_mask1", 64'(log_mask[base+1]), 64'h01);
    run("ld2u", 1'b0, 2'd1, 1'b0, 20'h08007, 64'd0, 64'hBEEF, 2);
    run("ld2s", 1'b0, 2'd1, 1'b1, 20'h08007, 64'd0, 64'hFFFFFFFFFFFFBEEF, 2);

    run("st_top", 1'b1, 2'd3, 1'b0, 20'hFFFF8, 64'hA1A2A3A4A5A6A7A8, 64'd0, 1);
    run("st_zero", 1'b1, 2'd3, 1'b0, 20'h00000, 64'hB1B2B3B4B5B6B7B8, 64'd0, 1);
    base = log_addr.size();
    run("ld_wrap", 1'b0, 2'd3, 1'b0, 20'hFFFFC, 64'd0, 64'hB5B6B7B8A1A2A3A4, 2);
    chk("wrap_addr0", 64'(log_addr[base]), 64'hFFFF8);
    chk("wrap_addr1", 64'(log_addr[base+1]), 64'h00000);

    // Word 0x08000 now holds EF22334455667788.
    do_req(1'b0, 2'd2, 1'b1, 20'h08004, 64'd0, 1'b0, rd, got, sok);
    chk("stall_rsp", 64'(got), 64'd1);
    chk("stall_rdata", rd, 64'hFFFFFFFFEF223344);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== rd || req_ready || mem_start_access) bad++;
    end
    chk("stall_stable", 64'(bad), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("stall_done_ready", 64'(req_ready), 64'd1);
    chk("stall_done_valid", 64'(rsp_valid), 64'd0);

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_signed = 1'b0;
    req_addr = 20'h08004; req_wdata = 64'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid_start", 64'(mem_start_access), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_start", 64'(mem_start_access), 64'd0);
    chk("mid_rst_idle", 64'(req_ready), 64'd1);
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || mem_start_access) bad++;
    end
    chk("mid_rst_quiet", 64'(bad), 64'd0);
    run("post_rst", 1'b0, 2'd3, 1'b0, 20'h08000, 64'd0, 64'hEF22334455667788, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
